// File: rtl/md_ctrl.sv
// md_ctrl: iterative multiply/divide unit that owns the architectural HI/LO registers.
// MULT/DIV keep busy high for 33 cycles; MTHI/MTLO write in a single cycle.
module md_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func,
  input  logic        isSign,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        readHILO,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  // state | meaning
  // IDLE  | ready for a new request; MTHI/MTLO complete here
  // MUL   | shift-add, one multiplier bit per cycle
  // DIV   | restoring divide, one quotient bit per cycle
  // FIX   | sign correction and HI/LO commit
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] F_MULT = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  localparam logic [2:0] F_MTHI = 3'b011;
  localparam logic [2:0] F_MTLO = 3'b100;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] opb;
  logic [63:0] acc;
  logic [31:0] rem;
  logic [31:0] quo;
  logic        sign_a;
  logic        sign_b;
  logic        op_div;
  logic        b_zero;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign a_mag = (isSign && A[31]) ? (32'd0 - A) : A;
  assign b_mag = (isSign && B[31]) ? (32'd0 - B) : B;

  // low half of acc holds the remaining multiplier bits, high half the partial sum
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);

  assign div_shift = {rem, quo[31]};
  assign div_ge    = (div_shift >= {1'b0, opb});
  assign div_diff  = div_shift[31:0] - opb;

  assign prod_fix = (sign_a ^ sign_b) ? (64'd0 - acc) : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? (32'd0 - quo) : quo;
  assign rem_fix  = sign_a ? (32'd0 - rem) : rem;

  assign busy  = (state != S_IDLE);
  assign stall = !rst && busy && (start || readHILO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      opb    <= 32'd0;
      acc    <= 64'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      op_div <= 1'b0;
      b_zero <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (func)
              F_MULT, F_DIV: begin
                sign_a <= isSign & A[31];
                sign_b <= isSign & B[31];
                opb    <= b_mag;
                cnt    <= 5'd0;
                op_div <= (func == F_DIV);
                b_zero <= (B == 32'd0);
                acc    <= {32'd0, a_mag};
                quo    <= a_mag;
                rem    <= 32'd0;
                state  <= (func == F_DIV) ? S_DIV : S_MUL;
              end
              F_MTHI:  HI <= A;
              F_MTLO:  LO <= A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= {mul_sum, acc[31:1]};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= S_FIX;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            rem <= div_ge ? div_diff : div_shift[31:0];
            quo <= {quo[30:0], div_ge};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= S_FIX;
          end
        end
        default: begin
          if (!flush) begin
            if (op_div) begin
              // a zero divisor leaves the dividend in rem, so only LO needs forcing
              HI <= rem_fix;
              LO <= b_zero ? 32'hFFFF_FFFF : quo_fix;
            end else begin
              HI <= prod_fix[63:32];
              LO <= prod_fix[31:0];
            end
            done <= 1'b1;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: scoreboard of expected HI/LO results,
// one task per scenario, outputs sampled on the falling clock edge.
module tb_md_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func;
  logic        isSign;
  logic [31:0] A;
  logic [31:0] B;
  logic        readHILO;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  localparam logic [2:0] F_MULT = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  localparam logic [2:0] F_MTHI = 3'b011;
  localparam logic [2:0] F_MTLO = 3'b100;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  md_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .isSign(isSign),
    .A(A), .B(B), .readHILO(readHILO), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // drive start for one cycle; returns at the falling edge of the first busy cycle
  task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; func = f; isSign = s; A = a; B = b;
    @(negedge clk);
    start = 1'b0; func = 3'b000;
  endtask

  task automatic wait_done(output int busy_n, output int stall_n, output int cycles, output bit seen);
    busy_n = 0; stall_n = 0; cycles = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (stall) stall_n++;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic count_done(input int n, output int dn);
    dn = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; func = F_MULT; A = 32'h5; B = 32'h6; readHILO = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
    total_cnt++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h want 0", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h want 0", LO); else pass_cnt++;
    rst = 1'b0; start = 1'b0; func = 3'b000; readHILO = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    logic [31:0] ta [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] tb [4] = '{32'h0000_0002, 32'h0000_0005, 32'h8000_0000, 32'hFFFF_FFFF};
    logic        ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      logic        s;
      logic [63:0] p;
      int          bn, sn, cy;
      bit          seen;
      res_t        r;
      if (i < 4) begin
        a = ta[i]; b = tb[i]; s = ts[i];
      end else begin
        a = $urandom; b = $urandom; s = 1'(i & 1);
      end
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = {32'd0, a} * {32'd0, b};
      sb_q.push_back({p[63:32], p[31:0]});
      issue(F_MULT, s, a, b);
      wait_done(bn, sn, cy, seen);
      total_cnt++; if (!seen) $display("FAIL mult%0d_timeout: no done within 100 cycles", i); else pass_cnt++;
      total_cnt++; if (cy != 33) $display("FAIL mult%0d_latency: got %0d want 33", i, cy); else pass_cnt++;
      total_cnt++; if (bn != 33) $display("FAIL mult%0d_busy_cycles: got %0d want 33", i, bn); else pass_cnt++;
      if (sb_q.size() != 0) begin
        r = sb_q.pop_front();
        total_cnt++; if (HI !== r.hi) $display("FAIL mult%0d_hi: got %h want %h", i, HI, r.hi); else pass_cnt++;
        total_cnt++; if (LO !== r.lo) $display("FAIL mult%0d_lo: got %h want %h", i, LO, r.lo); else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++; if (done !== 1'b0) $display("FAIL mult%0d_done_width: got %b want 0", i, done); else pass_cnt++;
    end
  endtask

  task automatic test_div();
    logic [31:0] ta [5] = '{32'h0000_1234, 32'h0000_1234, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0064};
    logic [31:0] tb [5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0007};
    logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      logic [31:0] a, b, eh, el;
      logic        s;
      longint      q, rm;
      int          bn, sn, cy;
      bit          seen;
      res_t        r;
      if (i < 5) begin
        a = ta[i]; b = tb[i]; s = ts[i];
      end else begin
        a = $urandom; b = $urandom >> (i * 3); s = 1'(i & 1);
        if (b == 32'd0) b = 32'd3;
      end
      if (b == 32'd0) begin
        eh = a; el = 32'hFFFF_FFFF;
      end else if (s) begin
        q  = longint'($signed(a)) / longint'($signed(b));
        rm = longint'($signed(a)) % longint'($signed(b));
        el = q[31:0]; eh = rm[31:0];
      end else begin
        el = a / b; eh = a % b;
      end
      sb_q.push_back({eh, el});
      issue(F_DIV, s, a, b);
      wait_done(bn, sn, cy, seen);
      total_cnt++; if (!seen) $display("FAIL div%0d_timeout: no done within 100 cycles", i); else pass_cnt++;
      total_cnt++; if (cy != 33) $display("FAIL div%0d_latency: got %0d want 33", i, cy); else pass_cnt++;
      if (sb_q.size() != 0) begin
        r = sb_q.pop_front();
        total_cnt++; if (HI !== r.hi) $display("FAIL div%0d_hi: got %h want %h", i, HI, r.hi); else pass_cnt++;
        total_cnt++; if (LO !== r.lo) $display("FAIL div%0d_lo: got %h want %h", i, LO, r.lo); else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_stall();
    int   bn, sn, cy;
    bit   seen;
    res_t r;
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    readHILO = 1'b1;
    issue(F_DIV, 1'b1, 32'hFFFF_FFF9, 32'h2);
    wait_done(bn, sn, cy, seen);
    total_cnt++; if (!seen) $display("FAIL divstall_timeout: no done within 100 cycles"); else pass_cnt++;
    total_cnt++; if (sn != 33) $display("FAIL divstall_stall_cycles: got %0d want 33", sn); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL divstall_done_cycle_stall: got %b want 0", stall); else pass_cnt++;
    if (sb_q.size() != 0) begin
      r = sb_q.pop_front();
      total_cnt++; if (HI !== r.hi) $display("FAIL divstall_hi: got %h want %h", HI, r.hi); else pass_cnt++;
      total_cnt++; if (LO !== r.lo) $display("FAIL divstall_lo: got %h want %h", LO, r.lo); else pass_cnt++;
    end
    readHILO = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_move_and_noop();
    logic [31:0] hi0, lo0;
    issue(F_MTHI, 1'b0, 32'hDEAD_0001, 32'h0);
    total_cnt++; if (HI !== 32'hDEAD_0001) $display("FAIL mthi_hi: got %h want dead0001", HI); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL mthi_done: got %b want 0", done); else pass_cnt++;
    issue(F_MTLO, 1'b0, 32'hBEEF_0002, 32'h0);
    total_cnt++; if (LO !== 32'hBEEF_0002) $display("FAIL mtlo_lo: got %h want beef0002", LO); else pass_cnt++;
    total_cnt++; if (HI !== 32'hDEAD_0001) $display("FAIL mtlo_hi_kept: got %h want dead0001", HI); else pass_cnt++;
    hi0 = HI; lo0 = LO;
    issue(3'b111, 1'b1, 32'h1111_1111, 32'h2222_2222);
    issue(3'b000, 1'b0, 32'h3333_3333, 32'h4444_4444);
    total_cnt++; if (busy !== 1'b0) $display("FAIL noop_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (HI !== hi0 || LO !== lo0) $display("FAIL noop_hilo: got %h/%h want %h/%h", HI, LO, hi0, lo0); else pass_cnt++;
    flush = 1'b1;
    issue(F_MTHI, 1'b0, 32'h5555_5555, 32'h0);
    issue(F_MULT, 1'b0, 32'h3, 32'h3);
    flush = 1'b0;
    total_cnt++; if (HI !== hi0) $display("FAIL flush_mthi_ignored: got %h want %h", HI, hi0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL flush_mult_ignored: got busy %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_flush();
    int dn;
    // flush in MUL at t+10, then MTLO in t+11
    issue(F_MULT, 1'b0, 32'h5, 32'h7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL flush_mul_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (HI !== 32'hDEAD_0001 || LO !== 32'hBEEF_0002) $display("FAIL flush_mul_hilo: got %h/%h want dead0001/beef0002", HI, LO); else pass_cnt++;
    issue(F_MTLO, 1'b0, 32'h5, 32'h0);
    total_cnt++; if (LO !== 32'h5) $display("FAIL flush_then_mtlo: got %h want 5", LO); else pass_cnt++;
    total_cnt++; if (HI !== 32'hDEAD_0001) $display("FAIL flush_then_mtlo_hi: got %h want dead0001", HI); else pass_cnt++;
    count_done(40, dn);
    total_cnt++; if (dn != 0) $display("FAIL flush_mul_no_done: got %0d pulses want 0", dn); else pass_cnt++;
    // flush in the FIX cycle
    issue(F_DIV, 1'b0, 32'h64, 32'h7);
    repeat (32) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total_cnt++; if (done !== 1'b0) $display("FAIL flush_fix_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (HI !== 32'hDEAD_0001 || LO !== 32'h5) $display("FAIL flush_fix_hilo: got %h/%h want dead0001/00000005", HI, LO); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int   bn, sn, cy, dn;
    bit   seen;
    res_t r;
    sb_q.push_back({32'd2, 32'd14});
    issue(F_DIV, 1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; func = F_MULT; A = 32'd3; B = 32'd3;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL b2b_stall_on_start: got %b want 1", stall); else pass_cnt++;
    @(negedge clk);
    start = 1'b0; func = 3'b000;
    wait_done(bn, sn, cy, seen);
    total_cnt++; if (!seen || cy != 28) $display("FAIL b2b_first_latency: got %0d (seen %b) want 28", cy, seen); else pass_cnt++;
    if (sb_q.size() != 0) begin
      r = sb_q.pop_front();
      total_cnt++; if ({HI, LO} !== {r.hi, r.lo}) $display("FAIL b2b_first_result: got %h/%h want %h/%h", HI, LO, r.hi, r.lo); else pass_cnt++;
    end
    // next request issued in the done cycle itself
    sb_q.push_back({32'd0, 32'd9});
    issue(F_MULT, 1'b0, 32'd3, 32'd3);
    wait_done(bn, sn, cy, seen);
    total_cnt++; if (!seen || cy != 33) $display("FAIL b2b_second_latency: got %0d (seen %b) want 33", cy, seen); else pass_cnt++;
    if (sb_q.size() != 0) begin
      r = sb_q.pop_front();
      total_cnt++; if ({HI, LO} !== {r.hi, r.lo}) $display("FAIL b2b_second_result: got %h/%h want %h/%h", HI, LO, r.hi, r.lo); else pass_cnt++;
    end
    count_done(40, dn);
    total_cnt++; if (dn != 0) $display("FAIL b2b_extra_done: got %0d pulses want 0", dn); else pass_cnt++;
  endtask

  task automatic test_reset_mid_div();
    int dn;
    issue(F_MTHI, 1'b0, 32'd77, 32'd0);
    issue(F_DIV, 1'b0, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1; readHILO = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL rstdiv_stall: got %b want 0", stall); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstdiv_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (HI !== 32'd0 || LO !== 32'd0) $display("FAIL rstdiv_hilo: got %h/%h want 0/0", HI, LO); else pass_cnt++;
    rst = 1'b0; readHILO = 1'b0;
    count_done(40, dn);
    total_cnt++; if (dn != 0) $display("FAIL rstdiv_no_done: got %0d pulses want 0", dn); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; func = 3'b000; isSign = 1'b0;
    A = 32'd0; B = 32'd0; readHILO = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_stall();
    test_move_and_noop();
    test_flush();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  EX-stage request, valid this cycle.
REQ-005 func  in  3  operation: 3'b001 MULT, 3'b010 DIV, 3'b011 MTHI, 3'b100 MTLO; other codes mean no-op.
REQ-006 isSign  in  1  1 = signed MULT/DIV, 0 = unsigned.
REQ-007 A  in  32  forwarded rs operand.
REQ-008 B  in  32  forwarded rt operand.
REQ-009 readHILO  in  1  MFHI/MFLO currently in EX.
REQ-010 flush  in  1  EX flush from the controller.
REQ-011 busy  out  1  iterative operation in progress.
REQ-012 stall  out  1  pipeline hold request to stall detect.
REQ-013 done  out  1  one-cycle pulse when the HI/LO result is committed.
REQ-014 HI  out  32  architectural HI register.
REQ-015 LO  out  32  architectural LO register.

Function
REQ-016 FSM states: IDLE, MUL, DIV, FIX; busy=1 in MUL, DIV and FIX only.
REQ-017 IDLE with start=1, flush=0 and func=MULT or DIV: latch |A| and |B| if isSign=1 (raw operands otherwise), the sign bits and isSign; clear the counter; go to MUL or DIV.
REQ-018 MUL: radix-2 shift-add on a 64-bit accumulator, one bit per cycle, for 32 cycles (counter 0..31); then go to FIX.
REQ-019 DIV: restoring divide, one quotient bit per cycle, for 32 cycles with a 33-bit partial remainder; then go to FIX.
REQ-020 FIX (1 cycle), signed MULT: negate the 64-bit product if sA^sB. Result: HI=product[63:32], LO=product[31:0].
REQ-021 FIX, signed DIV: LO = quotient, negated if sA^sB; HI = remainder, negated if sA.
REQ-022 FIX writes HI/LO at its clock edge, then returns to IDLE; done=1 for exactly the following cycle.
REQ-023 Latency: start sampled at edge t; busy=1 for cycles t+1..t+33; HI/LO hold the new values and done=1 in cycle t+34.
REQ-024 Divide by zero (B==0), signed or unsigned: HI=A, LO=32'hFFFFFFFF; latency unchanged.
REQ-025 Signed 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
REQ-026 IDLE, start=1, func=MTHI: HI<=A at the next edge; MTLO: LO<=A; busy stays 0; no done pulse.
REQ-027 start while busy=1 is ignored; upstream holds the instruction via stall.
REQ-028 stall = busy && (start || readHILO); stall is combinational from the current inputs and state.
REQ-029 A MFHI/MFLO in the cycle where done=1 reads the new HI/LO with no stall.
REQ-030 flush=1 in MUL/DIV/FIX: go to IDLE at the next edge; HI/LO unchanged; no done pulse.
REQ-031 flush=1 together with start in IDLE: start is ignored, including MTHI/MTLO.
REQ-032 Undefined func codes with start=1 leave all state unchanged.

Reset
REQ-033 rst=1 at an edge: state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0; this overrides start, flush and any in-flight operation.
REQ-034 While rst=1, stall=0.

Verification
REQ-035 Unsigned MULT A=32'hFFFFFFFF, B=32'h2 -> cycle t+34: HI=32'h1, LO=32'hFFFFFFFE, done=1; busy high exactly 33 cycles.
REQ-036 Signed DIV A=-7 (32'hFFFFFFF9), B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); readHILO=1 held during busy -> stall=1 throughout, 0 in the done cycle.
REQ-037 DIV with B=0, A=32'h1234 -> HI=32'h1234, LO=32'hFFFFFFFF after 33 busy cycles; signed 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
REQ-038 MULT started, flush at t+10 -> IDLE at t+11; HI/LO keep their prior values; no done pulse; a new MTLO A=5 at t+11 -> LO=5 at t+12.
REQ-039 rst asserted mid-DIV (t+20) -> next cycle busy=0, HI=LO=0; a second start during busy is ignored, and only the first result commits.
